// File: rtl/digit_serial_pkg.sv
// Shared types and sizing helpers for the digit-serial adder/subtractor.
package digit_serial_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic int ndig(input int width, input int digit);
        return width / digit;
    endfunction

    // A counter always needs at least one bit, even for a single-digit word.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/digit_serial_adder_ripple_digit.sv
// One DIGIT-wide ripple-carry slice built from full-adder cells; reused every
// cycle of a digit-serial add.
module full_adder (
    input  logic a,
    input  logic b,
    input  logic ci,
    output logic s,
    output logic co
);
    assign s  = a ^ b ^ ci;
    assign co = (a & b) | (ci & (a ^ b));
endmodule

module ripple_digit #(
    parameter int DIGIT = 4
) (
    input  logic [DIGIT-1:0] a,
    input  logic [DIGIT-1:0] b,
    input  logic             ci,
    output logic [DIGIT-1:0] s,
    output logic             co,
    output logic             c_msb
);
    logic [DIGIT:0] c;

    assign c[0] = ci;

    for (genvar i = 0; i < DIGIT; i++) begin : g_fa
        full_adder u_fa (
            .a (a[i]),
            .b (b[i]),
            .ci(c[i]),
            .s (s[i]),
            .co(c[i+1])
        );
    end

    // Carry into the slice MSB is kept so the top can form signed overflow.
    assign co    = c[DIGIT];
    assign c_msb = c[DIGIT-1];
endmodule

// File: rtl/digit_serial_adder.sv
// Digit-serial adder/subtractor: one DIGIT-wide slice per clock, carry held
// in a flop between digits, valid/ready on both sides.
//
// state | meaning
// IDLE  | no operation in flight, ready for operands
// RUN   | processing one digit per cycle, counter selects the digit
// DONE  | result presented on sum/cout/ovf with out_valid until accepted
module digit_serial_adder
    import digit_serial_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DIGIT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             sub,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf
);
    localparam int NDIG = ndig(WIDTH, DIGIT);
    localparam int CW   = cnt_width(NDIG);
    localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

    if ((DIGIT < 1) || (WIDTH % DIGIT != 0)) begin : g_bad_params
        $error("digit_serial_adder: WIDTH must be a positive multiple of DIGIT");
    end

    state_t            state;
    state_t            state_nxt;
    logic              accept;
    logic              last;

    logic [WIDTH-1:0]  op_a;
    logic [WIDTH-1:0]  op_b;
    logic [WIDTH-1:0]  res;
    logic [WIDTH-1:0]  res_nxt;
    logic              carry;
    logic [CW-1:0]     cnt;

    logic [DIGIT-1:0]  slice_s;
    logic              slice_co;
    logic              slice_cm;

    ripple_digit #(.DIGIT(DIGIT)) u_slice (
        .a    (op_a[DIGIT-1:0]),
        .b    (op_b[DIGIT-1:0]),
        .ci   (carry),
        .s    (slice_s),
        .co   (slice_co),
        .c_msb(slice_cm)
    );

    // Digits enter at the MSB side, so after NDIG cycles the word is aligned.
    if (DIGIT == WIDTH) begin : g_single
        assign res_nxt = slice_s;
    end else begin : g_multi
        assign res_nxt = {slice_s, res[WIDTH-1:DIGIT]};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (in_valid) state_nxt = RUN;
            RUN:  if (last) state_nxt = DONE;
            DONE: if (out_ready) state_nxt = in_valid ? RUN : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE) || ((state == DONE) && out_ready);
        out_valid = (state == DONE);
        accept    = in_valid && in_ready;
        last      = (state == RUN) && (cnt == LAST);
    end

    // Subtraction is a + ~b + ~borrow, so b is inverted and cin flipped at capture.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_a  <= '0;
            op_b  <= '0;
            res   <= '0;
            carry <= 1'b0;
            cnt   <= '0;
            sum   <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else if (accept) begin
            op_a  <= a;
            op_b  <= b ^ {WIDTH{sub}};
            carry <= cin ^ sub;
            cnt   <= '0;
        end else if (state == RUN) begin
            op_a  <= op_a >> DIGIT;
            op_b  <= op_b >> DIGIT;
            res   <= res_nxt;
            carry <= slice_co;
            cnt   <= cnt + CW'(1);
            if (last) begin
                sum  <= res_nxt;
                cout <= slice_co;
                ovf  <= slice_co ^ slice_cm;
            end
        end
    end

endmodule

// File: tb/tb_digit_serial_adder.sv
// Self-checking bench for digit_serial_adder at WIDTH=8, DIGIT=4: vector table,
// stall/back-to-back and reset corner cases, then random ops against a model.
module tb_digit_serial_adder;

    localparam int W    = 8;
    localparam int D    = 4;
    localparam int NDIG = W / D;

    logic         clk;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         sub;
    logic         cin;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    digit_serial_adder #(.WIDTH(W), .DIGIT(D)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .sub      (sub),
        .cin      (cin),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .sum      (sum),
        .cout     (cout),
        .ovf      (ovf)
    );

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        logic         cin;
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
    } vec_t;

    exp_t q[$];
    vec_t tbl[7];
    int   checks = 0;
    int   fails  = 0;
    int   cyc    = 0;
    logic rand_rdy = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, req);
        end
    endtask

    function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                                   input logic ts, input logic tc);
        exp_t   e;
        longint ua = ta;
        longint ub = tb_v;
        longint sa = $signed(ta);
        longint sb = $signed(tb_v);
        longint r;
        longint sr;
        longint smax = (longint'(1) <<< (W - 1)) - 1;
        longint smin = -(longint'(1) <<< (W - 1));
        if (!ts) begin
            r      = ua + ub + longint'(tc);
            sr     = sa + sb + longint'(tc);
            e.cout = r[W];
        end else begin
            r      = ua - ub - longint'(tc);
            sr     = sa - sb - longint'(tc);
            e.cout = (ua >= ub + longint'(tc));
        end
        e.sum = r[W-1:0];
        e.ovf = (sr > smax) || (sr < smin);
        e.acc = 0;
        return e;
    endfunction

    task automatic send(input logic [W-1:0] ta, input logic [W-1:0] tb_v,
                        input logic ts, input logic tc, input exp_t e);
        int n = 0;
        @(negedge clk);
        a = ta; b = tb_v; sub = ts; cin = tc; in_valid = 1'b1;
        #1;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            #1;
            n++;
        end
        if (!in_ready) begin
            checks++;
            fails++;
            $display("FAIL accept_timeout: in_ready stayed 0, required 1");
        end else begin
            e.acc = cyc + 1;
            q.push_back(e);
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d results outstanding, required 0", q.size());
        end
    endtask

    // Output monitor: latency on the rising edge of out_valid, data on handshake.
    initial begin
        logic prev = 1'b0;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev = 1'b0;
            end else begin
                if (out_valid && !prev) begin
                    if (q.size() == 0) begin
                        checks++;
                        fails++;
                        $display("FAIL unexpected_valid: out_valid=1 with no op pending");
                    end else begin
                        chk("latency", 64'(cyc - q[0].acc), 64'(NDIG));
                    end
                end
                if (out_valid && out_ready && q.size() != 0) begin
                    e = q.pop_front();
                    chk("sum",  64'(sum),  64'(e.sum));
                    chk("cout", 64'(cout), 64'(e.cout));
                    chk("ovf",  64'(ovf),  64'(e.ovf));
                end
                prev = out_valid;
            end
        end
    end

    initial begin
        exp_t e;
        int   n;
        logic [W-1:0] ra, rb;
        logic rs, rc;

        tbl[0] = '{8'h3C, 8'h25, 1'b0, 1'b0, 8'h61, 1'b0, 1'b0};
        tbl[1] = '{8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[2] = '{8'h80, 8'h80, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1};
        tbl[3] = '{8'h05, 8'h07, 1'b1, 1'b0, 8'hFE, 1'b0, 1'b0};
        tbl[4] = '{8'hFF, 8'h01, 1'b0, 1'b1, 8'h01, 1'b1, 1'b0};
        tbl[5] = '{8'h80, 8'h01, 1'b1, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[6] = '{8'h00, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b0};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        a = '0; b = '0; sub = 1'b0; cin = 1'b0;
        #2;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_in_ready",  64'(in_ready),  64'd1);
        chk("rst_sum",       64'(sum),       64'd0);
        chk("rst_cout",      64'(cout),      64'd0);
        chk("rst_ovf",       64'(ovf),       64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        out_ready = 1'b1;

        for (int i = 0; i < 7; i++) begin
            e.sum = tbl[i].sum; e.cout = tbl[i].cout; e.ovf = tbl[i].ovf; e.acc = 0;
            send(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].cin, e);
        end
        drain();

        // Stall the result, then accept a new op on the same edge as the handshake.
        out_ready = 1'b0;
        e = '{8'h61, 1'b0, 1'b0, 0};
        send(8'h3C, 8'h25, 1'b0, 1'b0, e);
        n = 0;
        while (!out_valid && n < 20) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("hold_reach_valid", 64'(out_valid), 64'd1);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("hold_valid",    64'(out_valid), 64'd1);
            chk("hold_sum",      64'(sum),       64'h61);
            chk("hold_in_ready", 64'(in_ready),  64'd0);
        end
        @(negedge clk);
        out_ready = 1'b1;
        a = 8'h7F; b = 8'h01; sub = 1'b0; cin = 1'b0; in_valid = 1'b1;
        #1;
        chk("b2b_in_ready", 64'(in_ready), 64'd1);
        q.push_back('{8'h80, 1'b0, 1'b1, cyc + 1});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        #1;
        chk("b2b_valid_drop", 64'(out_valid), 64'd0);
        drain();

        // Reset while an operation is mid-RUN.
        e = model(8'h12, 8'h34, 1'b0, 1'b0);
        send(8'h12, 8'h34, 1'b0, 1'b0, e);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rstrun_valid", 64'(out_valid), 64'd0);
        chk("rstrun_sum",   64'(sum),       64'd0);
        chk("rstrun_cout",  64'(cout),      64'd0);
        chk("rstrun_ovf",   64'(ovf),       64'd1 - 64'd1);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstrun_in_ready", 64'(in_ready), 64'd1);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            #1;
            chk("rstrun_no_stale", 64'(out_valid), 64'd0);
        end

        rand_rdy = 1'b1;
        for (int i = 0; i < 10000; i++) begin
            repeat ($urandom_range(0, 1)) @(negedge clk);
            ra = W'($urandom); rb = W'($urandom);
            rs = 1'($urandom); rc = 1'($urandom);
            send(ra, rb, rs, rc, model(ra, rb, rs, rc));
        end
        drain();
        rand_rdy = 1'b0;
        out_ready = 1'b1;

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
